max7219_sched: RTL
==================

# max7219_sched

Display-update scheduler for the desk clock's MAX7219 8-digit LED driver. Runs the MAX7219 power-up configuration after reset, then arbitrates register writes between digit refreshes (requested by the timekeeping path on each time change) and intensity changes. It owns the three-wire serial bus (`uio_out[0]` load, `[1]` data, `[3]` clock) through one serializer sub-module, and sits between the clock register / BCD-to-segment logic and the top-level pin mux.

## Interface
Parameters:
- `CLK_DIV`, default 2: `i_clk` cycles per serial-clock half period (≥1).
- `INIT_INTENSITY`, default 4'h7: intensity value written during the init sequence.

Ports:
- `i_clk` in 1: system clock (~10 MHz).
- `i_reset_n` in 1: reset, synchronous, active-low.
- `i_update_stb` in 1: one-cycle request to refresh all 8 digits.
- `i_digits` in 64: raw segment bytes; `[8k+7:8k]` is digit k (k=0 is hours tens); bit 7 of each byte is DP, bits 6:0 are segments.
- `i_intensity` in 4: requested brightness, level-sensitive.
- `o_serial_load` out 1: MAX7219 LOAD; a rising edge latches the word.
- `o_serial_dout` out 1: serial data, MSB first.
- `o_serial_clk` out 1: serial clock; the device samples on the rising edge.
- `o_busy` out 1: high while any word is in flight or any request is pending.

## Operation
- States: `IDLE`, `INIT`, `INTENSITY`, `REFRESH`.
  - Each non-idle state issues words to the serializer one at a time.
  - A word index advances on serializer `done`.
- On exit from reset: enter `INIT`.
  - Words in order: `0x0C01`, `0x0900`, `0x0B07`, `0x0A0` & `INIT_INTENSITY`, `0x0F00`.
  - Then `INIT` forces a `REFRESH`.
  - Shadow intensity register ← `INIT_INTENSITY`.
- `REFRESH`:
  - On entry, snapshot `i_digits` into a 64-bit register. Later changes to `i_digits` do not affect the running refresh.
  - Issues `{8'(k+1), digit_k}` for k=0..7, in ascending address order.
- Pending flags:
  - `refresh_pend` is set by `i_update_stb` in any state, including during `REFRESH`. Multiple strobes coalesce into one pending refresh.
  - `int_pend` is set when `i_intensity` ≠ shadow. It is evaluated only at arbitration.
- Arbitration happens only in `IDLE`, and only between whole sequences. Priority: intensity > refresh.
- `INTENSITY`:
  - Issues `0x0A0` & `i_intensity`, sampled at entry.
  - Shadow ← the sampled value.
- `refresh_pend` clears on entry to `REFRESH`. A strobe on the entry cycle re-sets it.
- `i_update_stb` during reset is ignored.
- `o_busy` = (state ≠ `IDLE`) | `refresh_pend` | (`i_intensity` ≠ shadow).

## Timing
Reset values:
- `o_serial_load`=1, `o_serial_clk`=0, `o_serial_dout`=0, `o_busy`=0.
- State `IDLE`, pending flags 0, shadow = `INIT_INTENSITY`.

Startup:
- `INIT` begins on the first cycle after `i_reset_n` is sampled high.
- `o_busy`=1 from that cycle onward.

Word transfer, starting at cycle 0 (start accepted):
- Cycle 0: load falls.
- Each bit b=15..0: `o_serial_dout` is valid for 2·`CLK_DIV` cycles. `o_serial_clk` is low for the first `CLK_DIV` cycles and high for the second.
- Cycle 32·`CLK_DIV`+1: clock is low and load rises. `done` pulses on this cycle.
- Load stays high for at least 1 further cycle before the next word starts.
- Word period: 32·`CLK_DIV`+2 cycles.

Sequencing latency:
- `IDLE` to first load fall: 1 cycle after arbitration.
- Words within a sequence are back-to-back at the word period.
- Full refresh: 8 word periods.

Reset mid-word:
- On the next edge, load=1, clk=0, and the partial word is abandoned.
- `INIT` restarts after reset is released.

## Structure
- Shared package `max7219_pkg`:
  - Register address constants: `NOOP`=0, `DIGIT0`=1, `DECODE`=9, `INTENSITY`=0xA, `SCANLIM`=0xB, `SHUTDOWN`=0xC, `TEST`=0xF.
  - State enum.
  - Init word ROM function.
- Sub-module `max7219_shift`:
  - Ports: `i_clk`, `i_reset_n`, `i_word[15:0]`, `i_start`, `o_ready`, `o_done`, plus the three serial outputs.
  - Contains the bit counter and `CLK_DIV` counter. `i_start` is ignored while not ready.
- Top level `max7219_sched` holds the FSM, word index, snapshot, shadow and pending flags.

## Test plan
All scenarios use the MAX7219 mock and `CLK_DIV`=2.

- **Reset release** with `i_digits`=0x7E30_6D79_3333_5B5F -> exactly 13 loads: `0x0C01 0x0900 0x0B07 0x0A07 0x0F00`, then `0x015F 0x025B 0x0333 0x0433 0x0579 0x066D 0x0730 0x087E`. Loads are 66 cycles apart. `o_busy` falls after the last load.
- **Single strobe in `IDLE`** -> first load fall 2 cycles after the strobe; 8 digit words; mock digits match. `o_busy` is high throughout.
- **Three strobes during a refresh, with `i_digits` changed mid-refresh** -> the running refresh shows the old snapshot. Exactly one further refresh follows, showing the new values.
- **`i_intensity` 7→3 during a refresh, together with a pending strobe** -> the current refresh completes, then `0x0A03`, then the refresh. Holding 3 afterward produces no further intensity words.
- **`i_reset_n` low for 1 cycle at bit 9 of a digit word** -> the next cycle shows load=1, clk=0, dout=0. No latch of the partial word in the mock. The full init sequence replays.

Source files
------------

// File: rtl/max7219_pkg.sv
// MAX7219 register map, scheduler states and power-up word ROM
// shared by the display scheduler and its serializer.
package max7219_pkg;

  localparam logic [7:0] NOOP      = 8'h00;
  localparam logic [7:0] DIGIT0    = 8'h01;
  localparam logic [7:0] DECODE    = 8'h09;
  localparam logic [7:0] INTENSITY = 8'h0A;
  localparam logic [7:0] SCANLIM   = 8'h0B;
  localparam logic [7:0] SHUTDOWN  = 8'h0C;
  localparam logic [7:0] TEST      = 8'h0F;

  localparam int INIT_LAST = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_INTENSITY,
    ST_REFRESH
  } state_t;

  function automatic logic [15:0] init_word(
    input logic [2:0] idx,
    input logic [3:0] inten
  );
    unique case (idx)
      3'd0:    init_word = {SHUTDOWN, 8'h01};
      3'd1:    init_word = {DECODE, 8'h00};
      3'd2:    init_word = {SCANLIM, 8'h07};
      3'd3:    init_word = {INTENSITY, 4'h0, inten};
      default: init_word = {TEST, 8'h00};
    endcase
  endfunction

endpackage

// File: rtl/max7219_shift.sv
// 16-bit MSB-first serializer for the MAX7219 three-wire bus;
// one word per start, done pulses with the LOAD rising edge.
module max7219_shift #(
  parameter int CLK_DIV = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [15:0] i_word,
  input  logic        i_start,
  output logic        o_ready,
  output logic        o_done,
  output logic        o_serial_load,
  output logic        o_serial_dout,
  output logic        o_serial_clk
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic          busy;
  logic          tail;
  logic [DW-1:0] div;
  logic [3:0]    bitn;
  logic [15:0]   sr;

  assign o_ready = !busy;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      busy          <= 1'b0;
      tail          <= 1'b0;
      div           <= '0;
      bitn          <= '0;
      sr            <= '0;
      o_done        <= 1'b0;
      o_serial_load <= 1'b1;
      o_serial_clk  <= 1'b0;
      o_serial_dout <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (!busy) begin
        if (i_start) begin
          busy          <= 1'b1;
          tail          <= 1'b0;
          div           <= '0;
          bitn          <= 4'd15;
          sr            <= {i_word[14:0], 1'b0};
          o_serial_dout <= i_word[15];
          o_serial_load <= 1'b0;
          o_serial_clk  <= 1'b0;
        end
      end else if (tail) begin
        busy          <= 1'b0;
        tail          <= 1'b0;
        o_done        <= 1'b1;
        o_serial_load <= 1'b1;
        o_serial_dout <= 1'b0;
      end else if (div != DIV_MAX) begin
        div <= div + 1'b1;
      end else begin
        div <= '0;
        if (!o_serial_clk) begin
          o_serial_clk <= 1'b1;
        end else begin
          o_serial_clk <= 1'b0;
          // one extra clk-low cycle after bit 0 before LOAD rises
          if (bitn == 4'd0) begin
            tail <= 1'b1;
          end else begin
            bitn          <= bitn - 4'd1;
            o_serial_dout <= sr[15];
            sr            <= {sr[14:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/max7219_sched.sv
// Desk-clock MAX7219 update scheduler: power-up init, then
// intensity-over-refresh arbitration between whole sequences.
import max7219_pkg::*;

module max7219_sched #(
  parameter int         CLK_DIV        = 2,
  parameter logic [3:0] INIT_INTENSITY = 4'h7
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_update_stb,
  input  logic [63:0] i_digits,
  input  logic [3:0]  i_intensity,
  output logic        o_serial_load,
  output logic        o_serial_dout,
  output logic        o_serial_clk,
  output logic        o_busy
);

  state_t      state;
  state_t      nstate;
  logic [2:0]  idx;
  logic [2:0]  nidx;
  logic [63:0] snap;
  logic [3:0]  shadow;
  logic [3:0]  shadow_d;
  logic        shadow_en;
  logic        snap_en;
  logic        pend_clr;
  logic        refresh_pend;
  logic        boot;
  logic        int_pend;
  logic [15:0] word;
  logic        start;
  logic        sh_ready;
  logic        sh_done;

  assign int_pend = (i_intensity != shadow);
  assign o_busy   = (state != ST_IDLE) | refresh_pend | int_pend;

  max7219_shift #(
    .CLK_DIV(CLK_DIV)
  ) u_shift (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_word        (word),
    .i_start       (start),
    .o_ready       (sh_ready),
    .o_done        (sh_done),
    .o_serial_load (o_serial_load),
    .o_serial_dout (o_serial_dout),
    .o_serial_clk  (o_serial_clk)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      snap         <= '0;
      shadow       <= INIT_INTENSITY;
      refresh_pend <= 1'b0;
      boot         <= 1'b1;
    end else begin
      state        <= nstate;
      idx          <= nidx;
      refresh_pend <= i_update_stb | (refresh_pend & !pend_clr);
      if (snap_en)   snap   <= i_digits;
      if (shadow_en) shadow <= shadow_d;
      if (nstate == ST_INIT) boot <= 1'b0;
    end
  end

  // first word of each sequence is issued in the cycle that leaves
  // IDLE, later words in the cycle the previous one is latched
  always_comb begin
    nstate    = state;
    nidx      = idx;
    word      = '0;
    start     = 1'b0;
    snap_en   = 1'b0;
    shadow_en = 1'b0;
    shadow_d  = shadow;
    pend_clr  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (sh_ready) begin
          if (boot) begin
            nstate    = ST_INIT;
            nidx      = '0;
            word      = init_word(3'd0, INIT_INTENSITY);
            start     = 1'b1;
            shadow_en = 1'b1;
            shadow_d  = INIT_INTENSITY;
          end else if (int_pend) begin
            nstate    = ST_INTENSITY;
            word      = {INTENSITY, 4'h0, i_intensity};
            start     = 1'b1;
            shadow_en = 1'b1;
            shadow_d  = i_intensity;
          end else if (refresh_pend) begin
            nstate   = ST_REFRESH;
            nidx     = '0;
            word     = {DIGIT0, i_digits[7:0]};
            start    = 1'b1;
            snap_en  = 1'b1;
            pend_clr = 1'b1;
          end
        end
      end
      ST_INIT: begin
        if (sh_done) begin
          if (idx == 3'(INIT_LAST)) begin
            nstate   = ST_REFRESH;
            nidx     = '0;
            word     = {DIGIT0, i_digits[7:0]};
            start    = 1'b1;
            snap_en  = 1'b1;
            pend_clr = 1'b1;
          end else begin
            nidx  = idx + 3'd1;
            word  = init_word(nidx, INIT_INTENSITY);
            start = 1'b1;
          end
        end
      end
      ST_REFRESH: begin
        if (sh_done) begin
          if (idx == 3'd7) begin
            nstate = ST_IDLE;
          end else begin
            nidx  = idx + 3'd1;
            word  = {DIGIT0 + {5'd0, nidx}, snap[{nidx, 3'b000} +: 8]};
            start = 1'b1;
          end
        end
      end
      ST_INTENSITY: begin
        if (sh_done) nstate = ST_IDLE;
      end
      default: nstate = ST_IDLE;
    endcase
  end

endmodule
